// File: rtl/axi_pkg.sv
// Shared AXI / AXI4-Lite struct types and lane/width helpers used by the
// Lite-to-AXI upsizer.
package axi_pkg;

    localparam int unsigned DefAddrWidth = 32;
    localparam int unsigned DefLiteWidth = 32;
    localparam int unsigned DefAxiWidth  = 64;
    localparam int unsigned DefIdWidth   = 1;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] RespOkay   = 2'b00;

    typedef struct packed {
        logic [DefAddrWidth-1:0] addr;
        logic [2:0]              prot;
    } lite_ax_t;

    typedef struct packed {
        logic [DefLiteWidth-1:0]   data;
        logic [DefLiteWidth/8-1:0] strb;
    } lite_w_t;

    typedef struct packed {
        logic [1:0] resp;
    } lite_b_t;

    typedef struct packed {
        logic [DefLiteWidth-1:0] data;
        logic [1:0]              resp;
    } lite_r_t;

    typedef struct packed {
        lite_ax_t aw;
        logic     aw_valid;
        lite_w_t  w;
        logic     w_valid;
        logic     b_ready;
        lite_ax_t ar;
        logic     ar_valid;
        logic     r_ready;
    } def_lite_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        lite_b_t b;
        logic    b_valid;
        logic    ar_ready;
        lite_r_t r;
        logic    r_valid;
    } def_lite_resp_t;

    typedef struct packed {
        logic [DefIdWidth-1:0]   id;
        logic [DefAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic                    lock;
        logic [3:0]              cache;
        logic [2:0]              prot;
        logic [3:0]              qos;
        logic [3:0]              region;
        logic [0:0]              user;
    } axi_ax_t;

    typedef struct packed {
        logic [DefAxiWidth-1:0]   data;
        logic [DefAxiWidth/8-1:0] strb;
        logic                     last;
        logic [0:0]               user;
    } axi_w_t;

    typedef struct packed {
        logic [DefIdWidth-1:0] id;
        logic [1:0]            resp;
        logic [0:0]            user;
    } axi_b_t;

    typedef struct packed {
        logic [DefIdWidth-1:0]  id;
        logic [DefAxiWidth-1:0] data;
        logic [1:0]             resp;
        logic                   last;
        logic [0:0]             user;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } def_axi_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        axi_b_t b;
        logic   r_valid;
        axi_r_t r;
    } def_axi_resp_t;

    function automatic logic [2:0] size_from_width(input int unsigned width);
        return 3'($clog2(width / 8));
    endfunction

    // Index of the narrow word inside one wide beat that this address falls on.
    function automatic int unsigned lite_lane(input logic [63:0] addr,
                                              input int unsigned lite_w,
                                              input int unsigned axi_w);
        logic [63:0] word;
        word = addr >> $clog2(lite_w / 8);
        return 32'(word % 64'(axi_w / lite_w));
    endfunction

endpackage

// File: rtl/axi_lite_lane_fifo.sv
// Small lane-index FIFO without fall-through; keeps the lane of each accepted
// address until the matching data beat has passed.
module axi_lite_lane_fifo #(
    parameter int unsigned Depth  = 4,
    parameter int unsigned Width  = 1,
    localparam int unsigned StoreW = (Width > 0) ? Width : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push,
    input  logic [StoreW-1:0] din,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [StoreW-1:0] head
);

    localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW   = $clog2(Depth + 1);
    localparam int unsigned Slots  = 1 << PtrW;

    logic [StoreW-1:0] mem [Slots];
    logic [PtrW-1:0]   wr_ptr, rd_ptr;
    logic [CntW-1:0]   count;
    logic              push_ok, pop_ok;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_next(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_next(rd_ptr);
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (!push_ok && pop_ok) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/axi_lite_to_axi_upsize.sv
// AXI4-Lite slave to wider single-beat AXI4 master: steers write strobes onto
// the addressed lane and extracts read data from the lane recorded at AR time.
module axi_lite_to_axi_upsize
    import axi_pkg::*;
#(
    parameter int unsigned          LiteDataWidth = 32,
    parameter int unsigned          AxiDataWidth  = 64,
    parameter int unsigned          AddrWidth     = 32,
    parameter int unsigned          AxiIdWidth    = 1,
    parameter logic [AxiIdWidth-1:0] AxiId        = '0,
    parameter int unsigned          MaxReads      = 4,
    parameter int unsigned          MaxWrites     = 4,
    parameter type                  req_lite_t    = def_lite_req_t,
    parameter type                  resp_lite_t   = def_lite_resp_t,
    parameter type                  axi_req_t     = def_axi_req_t,
    parameter type                  axi_resp_t    = def_axi_resp_t
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  req_lite_t  slv_req_lite_i,
    output resp_lite_t slv_resp_lite_o,
    input  logic [3:0] slv_aw_cache_i,
    input  logic [3:0] slv_ar_cache_i,
    output axi_req_t   mst_req_o,
    input  axi_resp_t  mst_resp_i,
    output logic       busy_o
);

    localparam int unsigned Ratio    = AxiDataWidth / LiteDataWidth;
    localparam int unsigned LaneBits = $clog2(Ratio);
    localparam int unsigned LaneW    = (LaneBits > 0) ? LaneBits : 1;
    localparam int unsigned StrbW    = LiteDataWidth / 8;
    localparam int unsigned CntW     = $clog2(MaxWrites + 1);

    logic             en;
    logic [CntW-1:0]  wr_cnt;
    logic             aw_ok, w_ok, ar_ok;
    logic             aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic             wf_full, wf_empty, rf_full, rf_empty;
    logic [LaneW-1:0] aw_lane, ar_lane, w_lane, rf_head, r_lane;
    logic             unused_bits;

    // Handshakes toward both ports are held off while reset is asserted.
    assign en      = ~rst_i;
    assign aw_ok   = en & (wr_cnt < CntW'(MaxWrites));
    assign w_ok    = en & ~wf_empty;
    assign ar_ok   = en & ~rf_full;

    assign aw_hs   = aw_ok & slv_req_lite_i.aw_valid & mst_resp_i.aw_ready;
    assign w_hs    = w_ok & slv_req_lite_i.w_valid & mst_resp_i.w_ready;
    assign b_hs    = en & mst_resp_i.b_valid & slv_req_lite_i.b_ready;
    assign ar_hs   = ar_ok & slv_req_lite_i.ar_valid & mst_resp_i.ar_ready;
    assign r_hs    = en & mst_resp_i.r_valid & slv_req_lite_i.r_ready;

    assign aw_lane = LaneW'(lite_lane(64'(slv_req_lite_i.aw.addr), LiteDataWidth, AxiDataWidth));
    assign ar_lane = LaneW'(lite_lane(64'(slv_req_lite_i.ar.addr), LiteDataWidth, AxiDataWidth));
    // An R beat with nothing outstanding falls back to lane 0.
    assign r_lane  = rf_empty ? '0 : rf_head;
    assign busy_o  = (wr_cnt != '0) | ~rf_empty;

    axi_lite_lane_fifo #(.Depth(MaxWrites), .Width(LaneBits)) u_wr_lane_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (aw_hs),
        .din   (aw_lane),
        .pop   (w_hs),
        .full  (wf_full),
        .empty (wf_empty),
        .head  (w_lane)
    );

    axi_lite_lane_fifo #(.Depth(MaxReads), .Width(LaneBits)) u_rd_lane_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (ar_hs),
        .din   (ar_lane),
        .pop   (r_hs & ~rf_empty),
        .full  (rf_full),
        .empty (rf_empty),
        .head  (rf_head)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i)                                  wr_cnt <= '0;
        else if (aw_hs && !b_hs)                    wr_cnt <= wr_cnt + 1'b1;
        else if (b_hs && !aw_hs && wr_cnt != '0)    wr_cnt <= wr_cnt - 1'b1;
    end

    always_comb begin
        mst_req_o       = '0;
        slv_resp_lite_o = '0;

        mst_req_o.aw.id    = AxiId;
        mst_req_o.aw.addr  = slv_req_lite_i.aw.addr;
        mst_req_o.aw.prot  = slv_req_lite_i.aw.prot;
        mst_req_o.aw.size  = size_from_width(LiteDataWidth);
        mst_req_o.aw.burst = BurstFixed;
        mst_req_o.aw.cache = slv_aw_cache_i;
        mst_req_o.aw_valid       = aw_ok & slv_req_lite_i.aw_valid;
        slv_resp_lite_o.aw_ready = aw_ok & mst_resp_i.aw_ready;

        mst_req_o.w.data = {Ratio{slv_req_lite_i.w.data}};
        for (int unsigned i = 0; i < Ratio; i++) begin
            if (w_lane == LaneW'(i)) mst_req_o.w.strb[i*StrbW +: StrbW] = slv_req_lite_i.w.strb;
        end
        mst_req_o.w.last        = 1'b1;
        mst_req_o.w_valid       = w_ok & slv_req_lite_i.w_valid;
        slv_resp_lite_o.w_ready = w_ok & mst_resp_i.w_ready;

        slv_resp_lite_o.b.resp  = mst_resp_i.b.resp;
        slv_resp_lite_o.b_valid = en & mst_resp_i.b_valid;
        mst_req_o.b_ready       = en & slv_req_lite_i.b_ready;

        mst_req_o.ar.id    = AxiId;
        mst_req_o.ar.addr  = slv_req_lite_i.ar.addr;
        mst_req_o.ar.prot  = slv_req_lite_i.ar.prot;
        mst_req_o.ar.size  = size_from_width(LiteDataWidth);
        mst_req_o.ar.burst = BurstFixed;
        mst_req_o.ar.cache = slv_ar_cache_i;
        mst_req_o.ar_valid       = ar_ok & slv_req_lite_i.ar_valid;
        slv_resp_lite_o.ar_ready = ar_ok & mst_resp_i.ar_ready;

        for (int unsigned i = 0; i < Ratio; i++) begin
            if (r_lane == LaneW'(i))
                slv_resp_lite_o.r.data = mst_resp_i.r.data[i*LiteDataWidth +: LiteDataWidth];
        end
        slv_resp_lite_o.r.resp  = mst_resp_i.r.resp;
        slv_resp_lite_o.r_valid = en & mst_resp_i.r_valid;
        mst_req_o.r_ready       = en & slv_req_lite_i.r_ready;
    end

    assign unused_bits = ^{wf_full, mst_resp_i.b.id, mst_resp_i.b.user,
                           mst_resp_i.r.id, mst_resp_i.r.last, mst_resp_i.r.user};

endmodule

// File: tb/tb_axi_lite_to_axi_upsize.sv
// Bench for the Lite 32 -> AXI 64 upsizer: directed scenarios plus random
// traffic, all checked against a queue-based transaction model.
module tb_axi_lite_to_axi_upsize;
    import axi_pkg::*;

    localparam int MaxR = 2;
    localparam int MaxW = 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    def_lite_req_t  lreq;
    def_lite_resp_t lresp;
    def_axi_req_t   mreq;
    def_axi_resp_t  mresp;
    logic [3:0]     aw_cache, ar_cache;
    logic           busy;

    always #5 clk = ~clk;

    axi_lite_to_axi_upsize #(.MaxReads(MaxR), .MaxWrites(MaxW)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .slv_req_lite_i  (lreq),
        .slv_resp_lite_o (lresp),
        .slv_aw_cache_i  (aw_cache),
        .slv_ar_cache_i  (ar_cache),
        .mst_req_o       (mreq),
        .mst_resp_i      (mresp),
        .busy_o          (busy)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;
    // Model state: lanes of accepted-but-unserved writes/reads, writes awaiting B.
    int unsigned wq[$];
    int unsigned rq[$];
    int          wcnt  = 0;
    int          bpend = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // 32-bit words in a 64-bit beat: address bit 2 picks the upper word.
    function automatic int unsigned lane_of(input logic [31:0] a);
        return a[2] ? 1 : 0;
    endfunction

    function automatic axi_ax_t exp_ax(input lite_ax_t a, input logic [3:0] cache);
        axi_ax_t r;
        r       = '0;
        r.addr  = a.addr;
        r.prot  = a.prot;
        r.size  = 3'd2;
        r.cache = cache;
        return r;
    endfunction

    task automatic idle();
        lreq     = '0;
        mresp    = '0;
        aw_cache = 4'h0;
        ar_cache = 4'h0;
    endtask

    // One clock: compare every output at the falling edge, then advance the model.
    task automatic step();
        logic        e_aw, e_w, e_ar;
        logic [9:0]  ec;
        axi_w_t      ew;
        lite_r_t     er;
        @(negedge clk);
        assert (rst || !mresp.r_valid || rq.size() > 0) else $error("r_valid with no read outstanding");
        e_aw = !rst && wcnt < MaxW;
        e_w  = !rst && wq.size() > 0;
        e_ar = !rst && rq.size() < MaxR;
        ec = {e_aw & lreq.aw_valid, e_aw & mresp.aw_ready, e_w & lreq.w_valid, e_w & mresp.w_ready,
              e_ar & lreq.ar_valid, e_ar & mresp.ar_ready, !rst & mresp.r_valid, !rst & lreq.r_ready,
              !rst & mresp.b_valid, !rst & lreq.b_ready};
        check_val("ctl", 128'({mreq.aw_valid, lresp.aw_ready, mreq.w_valid, lresp.w_ready,
                               mreq.ar_valid, lresp.ar_ready, lresp.r_valid, mreq.r_ready,
                               lresp.b_valid, mreq.b_ready}), 128'(ec));
        check_val("busy", 128'(busy), 128'(wcnt != 0 || rq.size() != 0));
        if (ec[9]) check_val("aw", 128'(mreq.aw), 128'(exp_ax(lreq.aw, aw_cache)));
        if (ec[7]) begin
            ew      = '0;
            ew.data = {2{lreq.w.data}};
            ew.strb = (wq[0] != 0) ? {lreq.w.strb, 4'h0} : {4'h0, lreq.w.strb};
            ew.last = 1'b1;
            check_val("w", 128'(mreq.w), 128'(ew));
        end
        if (ec[5]) check_val("ar", 128'(mreq.ar), 128'(exp_ax(lreq.ar, ar_cache)));
        if (ec[3]) begin
            er.data = (rq.size() > 0 && rq[0] != 0) ? mresp.r.data[63:32] : mresp.r.data[31:0];
            er.resp = mresp.r.resp;
            check_val("r", 128'(lresp.r), 128'(er));
        end
        if (ec[1]) check_val("b", 128'(lresp.b.resp), 128'(mresp.b.resp));
        @(posedge clk);
        if (rst) begin
            wq.delete();
            rq.delete();
            wcnt  = 0;
            bpend = 0;
        end else begin
            if (ec[9] && mresp.aw_ready) begin wq.push_back(lane_of(lreq.aw.addr)); wcnt++; end
            if (ec[7] && mresp.w_ready)  begin void'(wq.pop_front()); bpend++; end
            if (ec[1] && lreq.b_ready)   begin wcnt--; bpend--; end
            if (ec[5] && mresp.ar_ready) rq.push_back(lane_of(lreq.ar.addr));
            if (ec[3] && lreq.r_ready && rq.size() > 0) void'(rq.pop_front());
        end
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state: everything asserted on the inputs, nothing may pass.
        lreq.aw_valid = 1'b1; lreq.w_valid = 1'b1; lreq.ar_valid = 1'b1;
        lreq.b_ready = 1'b1;  lreq.r_ready = 1'b1;
        mresp.aw_ready = 1'b1; mresp.w_ready = 1'b1; mresp.ar_ready = 1'b1;
        #2 check_val("rst_vld", 128'({mreq.aw_valid, mreq.w_valid, mreq.ar_valid, lresp.aw_ready,
                                      lresp.ar_ready, busy}), 128'(0));
        step();
        rst = 1'b0;
        idle();
        step();

        // Write lane steering
        lreq.aw.addr = 32'h104; lreq.aw_valid = 1'b1; mresp.aw_ready = 1'b1;
        lreq.w.data = 32'hDEADBEEF; lreq.w.strb = 4'hF; lreq.w_valid = 1'b1;
        mresp.w_ready = 1'b1; lreq.b_ready = 1'b1;
        #2 check_val("steer_w_early", 128'(mreq.w_valid), 128'(0));
        check_val("steer_size_len", 128'({mreq.aw.size, mreq.aw.len}), 128'({3'd2, 8'd0}));
        step();
        lreq.aw_valid = 1'b0;
        #2 check_val("steer_strb", 128'(mreq.w.strb), 128'(8'hF0));
        check_val("steer_data", 128'(mreq.w.data), 128'(64'hDEADBEEF_DEADBEEF));
        check_val("steer_last_vld", 128'({mreq.w.last, mreq.w_valid}), 128'(2'b11));
        step();
        lreq.w_valid = 1'b0; mresp.b_valid = 1'b1; mresp.b.resp = RespOkay;
        #2 check_val("steer_b", 128'({lresp.b_valid, lresp.b.resp, busy}), 128'({1'b1, 2'b00, 1'b1}));
        step();
        idle();
        #2 check_val("steer_idle", 128'(busy), 128'(0));
        step();

        // Read lane extraction
        lreq.ar.addr = 32'h204; lreq.ar_valid = 1'b1; mresp.ar_ready = 1'b1;
        step();
        lreq.ar_valid = 1'b0; mresp.r_valid = 1'b1; lreq.r_ready = 1'b1;
        mresp.r.data = 64'h11223344_55667788;
        #2 check_val("rd_hi", 128'(lresp.r.data), 128'(32'h11223344));
        step();
        idle();
        lreq.ar.addr = 32'h200; lreq.ar_valid = 1'b1; mresp.ar_ready = 1'b1;
        step();
        lreq.ar_valid = 1'b0; mresp.r_valid = 1'b1; lreq.r_ready = 1'b1;
        mresp.r.data = 64'h11223344_55667788;
        #2 check_val("rd_lo", 128'(lresp.r.data), 128'(32'h55667788));
        step();
        idle();

        // Write data arrives before its address
        lreq.w.data = 32'hCAFEF00D; lreq.w.strb = 4'h3; lreq.w_valid = 1'b1; mresp.w_ready = 1'b1;
        repeat (3) begin
            #2 check_val("wba_hold", 128'(mreq.w_valid), 128'(0));
            step();
        end
        lreq.aw.addr = 32'h10C; lreq.aw_valid = 1'b1; mresp.aw_ready = 1'b1;
        #2 check_val("wba_aw_cycle", 128'(mreq.w_valid), 128'(0));
        step();
        lreq.aw_valid = 1'b0;
        #2 check_val("wba_strb", 128'({mreq.w_valid, mreq.w.strb}), 128'({1'b1, 8'h30}));
        step();
        lreq.w_valid = 1'b0; mresp.b_valid = 1'b1; lreq.b_ready = 1'b1;
        step();
        idle();

        // Outstanding read limit (two)
        mresp.ar_ready = 1'b1; lreq.ar_valid = 1'b1;
        lreq.ar.addr = 32'h0; step();
        lreq.ar.addr = 32'h4; step();
        lreq.ar.addr = 32'h0;
        #2 check_val("lim_ar_blk", 128'(lresp.ar_ready), 128'(0));
        step();
        mresp.r_valid = 1'b1; lreq.r_ready = 1'b1; mresp.r.data = 64'hAAAAAAAA_BBBBBBBB;
        #2 check_val("lim_r0", 128'({lresp.r.data, lresp.ar_ready}), 128'({32'hBBBBBBBB, 1'b0}));
        step();
        #2 check_val("lim_r1", 128'({lresp.r.data, lresp.ar_ready}), 128'({32'hAAAAAAAA, 1'b1}));
        step();
        lreq.ar_valid = 1'b0;
        #2 check_val("lim_r2", 128'(lresp.r.data), 128'(32'hBBBBBBBB));
        step();
        idle();
        step();

        // Write counter with a single outstanding write
        mresp.aw_ready = 1'b1; mresp.w_ready = 1'b1;
        lreq.aw_valid = 1'b1; lreq.aw.addr = 32'h4;
        lreq.w_valid = 1'b1; lreq.w.data = 32'h0BADF00D; lreq.w.strb = 4'hF;
        step();
        lreq.aw.addr = 32'h0;
        #2 check_val("wc_block1", 128'(lresp.aw_ready), 128'(0));
        step();
        #2 check_val("wc_block2", 128'({lresp.aw_ready, mreq.aw_valid, busy}), 128'(3'b001));
        mresp.b_valid = 1'b1; lreq.b_ready = 1'b1;
        step();
        mresp.b_valid = 1'b0;
        #2 check_val("wc_open", 128'(lresp.aw_ready), 128'(1));
        step();
        lreq.aw_valid = 1'b0;
        step();
        lreq.w_valid = 1'b0; mresp.b_valid = 1'b1;
        #2 check_val("wc_busy_hi", 128'(busy), 128'(1));
        step();
        idle();
        #2 check_val("wc_busy_fall", 128'(busy), 128'(0));
        step();

        // Reset in the middle of two outstanding reads
        mresp.ar_ready = 1'b1; lreq.ar_valid = 1'b1; lreq.ar.addr = 32'h4;
        step();
        step();
        rst = 1'b1;
        lreq.aw_valid = 1'b1; lreq.w_valid = 1'b1; mresp.aw_ready = 1'b1; mresp.w_ready = 1'b1;
        #2 check_val("rst_mid_ctl", 128'({mreq.aw_valid, mreq.w_valid, mreq.ar_valid,
                                          lresp.aw_ready, lresp.ar_ready}), 128'(0));
        step();
        rst = 1'b0;
        idle();
        #2 check_val("rst_mid_busy", 128'(busy), 128'(0));
        lreq.ar.addr = 32'h8; lreq.ar_valid = 1'b1; mresp.ar_ready = 1'b1;
        step();
        lreq.ar_valid = 1'b0; mresp.r_valid = 1'b1; lreq.r_ready = 1'b1;
        mresp.r.data = 64'h01234567_89ABCDEF;
        #2 check_val("rst_fresh_r", 128'(lresp.r.data), 128'(32'h89ABCDEF));
        step();
        idle();
        step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst            = (i % 997 == 500);
            lreq.aw.addr   = $urandom();
            lreq.aw.prot   = 3'($urandom_range(0, 7));
            lreq.ar.addr   = $urandom();
            lreq.ar.prot   = 3'($urandom_range(0, 7));
            lreq.w.data    = $urandom();
            lreq.w.strb    = 4'($urandom_range(0, 15));
            lreq.aw_valid  = 1'($urandom_range(0, 1));
            lreq.w_valid   = 1'($urandom_range(0, 1));
            lreq.ar_valid  = 1'($urandom_range(0, 1));
            lreq.b_ready   = 1'($urandom_range(0, 1));
            lreq.r_ready   = 1'($urandom_range(0, 1));
            aw_cache       = 4'($urandom_range(0, 15));
            ar_cache       = 4'($urandom_range(0, 15));
            mresp.aw_ready = 1'($urandom_range(0, 1));
            mresp.w_ready  = 1'($urandom_range(0, 1));
            mresp.ar_ready = 1'($urandom_range(0, 1));
            mresp.b.resp   = 2'($urandom_range(0, 3));
            mresp.b.user   = 1'($urandom_range(0, 1));
            mresp.r.data   = {$urandom(), $urandom()};
            mresp.r.resp   = 2'($urandom_range(0, 3));
            mresp.b_valid  = (bpend > 0) && ($urandom_range(0, 1) == 1);
            mresp.r_valid  = (rq.size() > 0) && ($urandom_range(0, 1) == 1);
            step();
        end
        rst = 1'b0;
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
